// File: rtl/trsq8_irq_ctrl.sv
// Priority interrupt controller for the TRSQ8 core: synchronised sources, edge/level PENDING,
// single outstanding request (IDLE -> REQ -> SERVICE -> EOI), register port with one-cycle read latency.
module trsq8_irq_ctrl #(
  parameter int N_SRC       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_SRC-1:0] irq_src,
  input  logic             we,
  input  logic             re,
  input  logic [1:0]       addr,
  input  logic [7:0]       wdata,
  output logic [7:0]       rdata,
  output logic             irq,
  input  logic             irq_ack,
  output logic [2:0]       vector
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  localparam logic [1:0] ADDR_PENDING = 2'd0;
  localparam logic [1:0] ADDR_MASK    = 2'd1;
  localparam logic [1:0] ADDR_MODE    = 2'd2;
  localparam logic [1:0] ADDR_VECTOR  = 2'd3;

  state_t           state;
  logic [N_SRC-1:0] sync_q [SYNC_STAGES];
  logic [N_SRC-1:0] synced;
  logic [N_SRC-1:0] prev_lvl;
  logic [N_SRC-1:0] rise;
  logic [1:0]       fill_cnt;
  logic             filled;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] pending_nxt;
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] mode;
  logic [N_SRC-1:0] elig;
  logic [N_SRC-1:0] w1c;
  logic [N_SRC-1:0] ack_clr;
  logic [N_SRC-1:0] vec_sel;
  logic [2:0]       winner;
  logic             cur_elig;
  logic             ack_take;
  logic             eoi;
  logic             busy;

  function automatic logic [7:0] zext(input logic [N_SRC-1:0] v);
    logic [7:0] r;
    r            = '0;
    r[N_SRC-1:0] = v;
    return r;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= irq_src;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];

  // The synchroniser output is only a genuine sample once the reset zeros have flushed out;
  // prev_lvl resets high so a line already asserted at reset release never looks like an edge.
  assign filled = (fill_cnt == 2'(SYNC_STAGES));
  assign rise   = filled ? (synced & ~prev_lvl) : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fill_cnt <= '0;
      prev_lvl <= '1;
    end else begin
      if (!filled) fill_cnt <= fill_cnt + 2'd1;
      if (filled)  prev_lvl <= synced;
    end
  end

  assign busy     = (state != IDLE);
  assign ack_take = (state == REQ) && irq_ack;
  assign eoi      = (state == SERVICE) && we && (addr == ADDR_VECTOR);
  assign elig     = pending & mask;
  assign w1c      = (we && addr == ADDR_PENDING) ? wdata[N_SRC-1:0] : '0;

  always_comb begin
    vec_sel = '0;
    for (int i = 0; i < N_SRC; i++) vec_sel[i] = (3'(i) == vector);
  end

  assign ack_clr  = ack_take ? vec_sel : '0;
  assign cur_elig = |(elig & vec_sel);

  // Edge bits: clears first, then a same-cycle set wins. Level bits simply follow the synced line.
  assign pending_nxt = (mode & ((pending & ~w1c & ~ack_clr) | rise)) | (~mode & synced);

  always_comb begin
    winner = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (elig[i]) winner = 3'(i);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending <= '0;
      mask    <= '0;
      mode    <= '0;
    end else begin
      pending <= pending_nxt;
      if (we && addr == ADDR_MASK) mask <= wdata[N_SRC-1:0];
      if (we && addr == ADDR_MODE) mode <= wdata[N_SRC-1:0];
    end
  end

  // One request in flight: vector is frozen from the IDLE->REQ decision until EOI.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      irq    <= 1'b0;
      vector <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|elig) begin
            vector <= winner;
            state  <= REQ;
            irq    <= 1'b1;
          end
        end
        REQ: begin
          if (ack_take) begin
            state <= SERVICE;
            irq   <= 1'b0;
          end else if (!cur_elig) begin
            state <= IDLE;
            irq   <= 1'b0;
          end
        end
        SERVICE: begin
          if (eoi) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          irq   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata <= '0;
    end else if (re) begin
      case (addr)
        ADDR_PENDING: rdata <= zext(pending);
        ADDR_MASK:    rdata <= zext(mask);
        ADDR_MODE:    rdata <= zext(mode);
        default:      rdata <= {busy, 4'b0000, vector};
      endcase
    end
  end

endmodule

// File: tb/tb_trsq8_irq_ctrl.sv
// Randomised and directed bench for trsq8_irq_ctrl against a sample-history reference model.
module tb_trsq8_irq_ctrl;

  localparam int N = 8;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [N-1:0] irq_src = '0;
  logic         we = 1'b0;
  logic         re = 1'b0;
  logic [1:0]   addr = '0;
  logic [7:0]   wdata = '0;
  logic         irq_ack = 1'b0;
  logic [7:0]   rdata;
  logic         irq;
  logic [2:0]   vector;

  int errors = 0;
  int checks = 0;

  trsq8_irq_ctrl #(.N_SRC(N), .SYNC_STAGES(S)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .irq_src (irq_src),
    .we      (we),
    .re      (re),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .irq     (irq),
    .irq_ack (irq_ack),
    .vector  (vector)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: raw samples since reset; the controller sees the sample taken S edges ago.
  logic [N-1:0] raw_q[$];
  logic [N-1:0] m_last;
  logic [N-1:0] m_pend, m_mask, m_mode;
  int           m_phase;          // 0 idle, 1 requesting, 2 in service
  logic         m_irq;
  logic [2:0]   m_vec;
  logic [7:0]   m_rdata;

  task automatic model_reset();
    raw_q.delete();
    m_last  = '1;
    m_pend  = '0;
    m_mask  = '0;
    m_mode  = '0;
    m_phase = 0;
    m_irq   = 1'b0;
    m_vec   = '0;
    m_rdata = '0;
  endtask

  task automatic model_edge();
    logic [N-1:0] sy, rs, nxt, elig;
    bit           genuine, keep;
    int           win;
    genuine = (raw_q.size() >= S);
    sy      = genuine ? raw_q[0] : '0;
    rs      = genuine ? (sy & ~m_last) : '0;
    raw_q.push_back(irq_src);
    if (raw_q.size() > S) void'(raw_q.pop_front());
    elig = m_pend & m_mask;
    if (re) begin
      case (addr)
        2'd0:    m_rdata = m_pend;
        2'd1:    m_rdata = m_mask;
        2'd2:    m_rdata = m_mode;
        default: m_rdata = {(m_phase != 0), 4'b0000, m_vec};
      endcase
    end
    for (int i = 0; i < N; i++) begin
      if (!m_mode[i]) nxt[i] = sy[i];
      else begin
        keep = m_pend[i];
        if (we && addr == 2'd0 && wdata[i]) keep = 1'b0;
        if (m_phase == 1 && irq_ack && int'(m_vec) == i) keep = 1'b0;
        nxt[i] = keep | rs[i];
      end
    end
    case (m_phase)
      0: if (elig != 0) begin
        win = 0;
        for (int i = N - 1; i >= 0; i--) if (elig[i]) win = i;
        m_vec   = 3'(win);
        m_phase = 1;
        m_irq   = 1'b1;
      end
      1: if (irq_ack) begin
        m_phase = 2;
        m_irq   = 1'b0;
      end else if (!elig[m_vec]) begin
        m_phase = 0;
        m_irq   = 1'b0;
      end
      default: if (we && addr == 2'd3) m_phase = 0;
    endcase
    if (we && addr == 2'd1) m_mask = wdata;
    if (we && addr == 2'd2) m_mode = wdata;
    if (genuine) m_last = sy;
    m_pend = nxt;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_val("irq", irq, m_irq);
    check_val("vector", vector, m_vec);
    check_val("rdata", rdata, m_rdata);
    we      = 1'b0;
    re      = 1'b0;
    irq_ack = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    we = 1'b1; addr = a; wdata = d;
    step();
  endtask

  task automatic rd(input logic [1:0] a);
    re = 1'b1; addr = a;
    step();
  endtask

  task automatic ack();
    irq_ack = 1'b1;
    step();
  endtask

  task automatic wait_irq(input string tag);
    int n = 0;
    while (irq !== 1'b1 && n < 30) begin
      step();
      n++;
    end
    check_val(tag, irq, 1);
  endtask

  // Asserted between edges so the outputs must clear without a clock.
  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    #1;
    check_val("rst_irq", irq, 0);
    check_val("rst_rdata", rdata, 0);
    check_val("rst_vector", vector, 0);
    model_reset();
    we = 1'b0; re = 1'b0; irq_ack = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int lat;
    int n;
    model_reset();
    #12;
    check_val("init_irq", irq, 0);
    check_val("init_rdata", rdata, 0);
    check_val("init_vector", vector, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Edge source 0: latency from line rise to irq
    wr(2'd2, 8'hFF);
    wr(2'd1, 8'h01);
    repeat (3) step();
    irq_src[0] = 1'b1;
    lat = 0;
    while (irq !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    check_val("t1_latency", lat, S + 2);
    check_val("t1_vector", vector, 0);
    rd(2'd0);
    check_val("t1_pending", rdata, 8'h01);
    irq_src[0] = 1'b0;
    ack();
    wr(2'd3, 8'h00);
    repeat (3) step();

    // Simultaneous sources 5 and 2, then reset mid-service
    do_reset();
    repeat (3) step();
    wr(2'd1, 8'hFF);
    wr(2'd2, 8'hFF);
    irq_src = 8'h24;
    wait_irq("t2_irq_first");
    check_val("t2_vec_first", vector, 2);
    irq_src = 8'h00;
    ack();
    wr(2'd3, 8'h00);
    wait_irq("t2_irq_second");
    check_val("t2_vec_second", vector, 5);
    ack();
    rd(2'd3);
    check_val("t2_busy_read", rdata, 8'h85);
    do_reset();
    rd(2'd3);
    check_val("t3_busy_after_rst", rdata, 8'h00);
    rd(2'd1);
    check_val("t3_mask_after_rst", rdata, 8'h00);

    // No preemption during service of source 4
    repeat (3) step();
    wr(2'd1, 8'hFF);
    wr(2'd2, 8'hFF);
    irq_src = 8'h10;
    wait_irq("t4_irq");
    check_val("t4_vec", vector, 4);
    irq_src = 8'h00;
    ack();
    irq_src = 8'h02;
    repeat (6) step();
    check_val("t4_hold_irq", irq, 0);
    check_val("t4_hold_vec", vector, 4);
    wr(2'd3, 8'h00);
    wait_irq("t4_irq_after_eoi");
    check_val("t4_vec_after_eoi", vector, 1);
    ack();
    wr(2'd3, 8'h00);
    irq_src = 8'h00;

    // Level source 3 withdraws before ack
    do_reset();
    repeat (3) step();
    wr(2'd1, 8'hFF);
    wr(2'd2, 8'hF7);
    irq_src = 8'h08;
    wait_irq("t5_irq");
    check_val("t5_vec", vector, 3);
    irq_src = 8'h00;
    n = 0;
    while (irq !== 1'b0 && n < 10) begin
      step();
      n++;
    end
    check_val("t5_irq_drop", irq, 0);
    rd(2'd3);
    check_val("t5_idle", rdata, 8'h03);
    rd(2'd0);
    check_val("t5_pend3", rdata & 8'h08, 0);

    // Edge on source 6 coincident with its W1C
    do_reset();
    wr(2'd2, 8'hFF);
    repeat (4) step();
    irq_src[6] = 1'b1;
    repeat (S) step();
    wr(2'd0, 8'h40);
    rd(2'd0);
    check_val("t6_pend6", rdata & 8'h40, 8'h40);
    irq_src = 8'h00;

    // Randomised traffic
    do_reset();
    wr(2'd1, 8'hFF);
    for (int i = 0; i < 3000; i++) begin
      int r;
      if (i % 1000 == 999) begin
        do_reset();
        wr(2'd1, 8'($urandom) | 8'h81);
      end
      irq_src = irq_src ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      r = $urandom_range(0, 99);
      if (r < 6) begin
        we = 1'b1; addr = 2'($urandom_range(0, 2)); wdata = 8'($urandom);
      end else if (r < 20) begin
        we = 1'b1; addr = 2'd3; wdata = 8'($urandom);
      end
      re = ($urandom_range(0, 2) == 0);
      if (!we) addr = 2'($urandom_range(0, 3));
      irq_ack = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/trsq8_irq_ctrl.md
TRSQ8_IRQ_CTRL -- requirements
Module: trsq8_irq_ctrl

Interface
REQ-001 The block SHALL have parameter N_SRC, default 8, number of interrupt sources (legal range 1..8).
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, synchroniser depth on each irq_src line (legal range 2..3).
REQ-003 Port clk  input  1  single clock; all state on rising edge.
REQ-004 Port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 Port irq_src  input  N_SRC  asynchronous interrupt sources; bit 0 highest priority.
REQ-006 Port we  input  1  register write strobe, one cycle.
REQ-007 Port re  input  1  register read strobe, one cycle.
REQ-008 Port addr  input  2  register select: 0 PENDING, 1 MASK, 2 MODE, 3 VECTOR/EOI.
REQ-009 Port wdata  input  8  write data.
REQ-010 Port rdata  output  8  read data, registered.
REQ-011 Port irq  output  1  request to TRSQ8 core irq input, registered.
REQ-012 Port irq_ack  input  1  core acceptance pulse, one cycle.
REQ-013 Port vector  output  3  index of the source being requested/serviced.

Function
REQ-014 Each irq_src bit SHALL pass through SYNC_STAGES flops before use; there is no other path from irq_src to state.
REQ-015 MODE bit i = 1 (edge): PENDING[i] SHALL set on a 0->1 transition of synced source i.
REQ-016 MODE bit i = 0 (level): PENDING[i] SHALL equal the synced level of source i each cycle; W1C and ack clears have no effect on it.
REQ-017 Write addr 0: each 1 bit SHALL clear the matching edge-mode PENDING bit; a set event in the same cycle SHALL win.
REQ-018 Writes to addr 1/2 SHALL load MASK/MODE from wdata[N_SRC-1:0]; bits >= N_SRC SHALL read 0 and ignore writes.
REQ-019 Read: rdata SHALL present the addressed register one cycle after re; addr 3 reads {busy, 4'b0, vector}; rdata holds otherwise.
REQ-020 Eligible set = PENDING & MASK; winner = lowest eligible index.
REQ-021 State machine SHALL have states IDLE, REQ, SERVICE.
REQ-022 IDLE: if eligible set non-empty, SHALL latch winner into vector, go to REQ, assert irq on the next edge (irq asserts exactly 1 cycle after PENDING&MASK becomes non-zero).
REQ-023 REQ: irq SHALL stay 1; on irq_ack go to SERVICE, drop irq, and clear PENDING[vector] if edge mode.
REQ-024 REQ: if PENDING[vector]&MASK[vector] falls to 0 before irq_ack, SHALL return to IDLE with irq 0 next cycle; re-arbitrate from IDLE.
REQ-025 vector SHALL not change while in REQ or SERVICE, even if a higher-priority source becomes eligible (no nesting, no preemption).
REQ-026 SERVICE: a write to addr 3 (any data) is EOI and SHALL return to IDLE; busy = (state != IDLE).
REQ-027 irq_ack in IDLE or SERVICE, and EOI outside SERVICE, SHALL be ignored.
REQ-028 Simultaneous irq_ack and EOI write in REQ: ack SHALL be taken, EOI ignored.
REQ-029 Edges arriving during SERVICE SHALL be held in PENDING and arbitrated after EOI.

Reset
REQ-030 On reset_n low, immediately and asynchronously: PENDING=0, MASK=0, MODE=0, state IDLE, irq=0, vector=0, rdata=0, synchroniser flops=0.
REQ-031 After reset_n rises, a source already high SHALL not be seen as an edge in edge mode (synchroniser holds 0 then follows level; an edge is registered only if the line was seen low post-reset).
REQ-032 Reset during REQ or SERVICE SHALL abort the transaction with no residual pending state.

Verification
REQ-033 MODE=0xFF, MASK=0x01, pulse irq_src[0] -> PENDING=0x01, irq=1 at SYNC_STAGES+2 cycles after the edge, vector=0.
REQ-034 MASK=0xFF, MODE=0xFF, raise irq_src[5] and irq_src[2] same cycle -> vector=2; ack, EOI -> next request vector=5.
REQ-035 In SERVICE for source 4, raise irq_src[1] -> irq stays 0, vector stays 4; after EOI irq=1 with vector=1.
REQ-036 Level source 3 (MODE bit 3=0) in REQ, deassert irq_src[3] before ack -> irq=0, state IDLE, PENDING[3]=0.
REQ-037 Edge set on source 6 same cycle as W1C 0x40 -> PENDING[6]=1.
REQ-038 reset_n low mid-SERVICE -> irq=0, rdata=0, all registers 0 without a clock edge; busy reads 0 after release.
